uart_rx_ctrl: RTL and testbench

- Sequences the UART receive datapath (UartRX) and buffers received bytes for the Hack CPU.
- Watches UartRX out[15] for byte completion, pushes the byte into an internal FIFO, then pulses UartRX clear to re-arm it.
- Presents the FIFO head to the CPU as a memory-mapped word. Uses the same "out[15]=1 means nothing available" convention as UartRX, so software polls it the same way.

---
 rtl/uart_rx_ctrl.sv | 146 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the UartRX clear/arm/wait handshake and buffers
// received bytes in a first-word-fall-through FIFO for the Hack CPU.
// CPU word: [15]=empty, [14]=overrun, [13:8]=0, [7:0]=head byte (0 when empty).
// Optional build macro UART_RX_CTRL_IRQ_EN adds a registered irq output
// raised at or above WATERMARK entries, or while overrun is set.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
`ifdef UART_RX_CTRL_IRQ_EN
    ,
    parameter int unsigned WATERMARK = 8
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   rx_data,
    output logic          rx_clear,
    input  logic          rd,
    output logic [15:0]   out,
    output logic [AW:0]   count
`ifdef UART_RX_CTRL_IRQ_EN
    ,
    output logic          irq
`endif
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          push;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovr_set;
    logic          overrun;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    mem [DEPTH];

    // Only the status bit and the byte lane of the UartRX word are meaningful.
    logic          unused_rx_hi;
    assign unused_rx_hi = ^rx_data[14:8];

    // FSM state register; reset lands in CLR because UartRX itself has no reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_CLR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: clear UartRX, wait for it to report idle, then wait for a byte.
    always_comb begin
        state_next = state;
        case (state)
            ST_CLR:  state_next = ST_ARM;
            ST_ARM:  if (rx_data[15]) state_next = ST_WAIT;
            ST_WAIT: if (!rx_data[15]) state_next = ST_CLR;
            default: state_next = ST_CLR;
        endcase
    end

    // FSM outputs: clear pulse in CLR (held low during reset), push request in WAIT.
    always_comb begin
        rx_clear = 1'b0;
        push     = 1'b0;
        case (state)
            ST_CLR:  rx_clear = ~reset;
            ST_WAIT: push     = ~rx_data[15];
            default: ;
        endcase
    end

    // FIFO qualifiers: a pop frees a slot, so a push while full succeeds with rd.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_pop  = rd & ~empty;
        do_push = push & (~full | do_pop);
        ovr_set = push & full & ~do_pop;
    end

    // Pointers, fill count and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (do_pop) begin
                overrun <= 1'b0;
            end
        end
    end

    // Byte storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_data[7:0];
        end
    end

    // CPU-visible word, head byte falls through combinationally.
    always_comb begin
        out = {empty, overrun, 6'b0, 8'h00};
        if (!empty) begin
            out[7:0] = mem[rd_ptr];
        end
    end

`ifdef UART_RX_CTRL_IRQ_EN
    // Level interrupt, one cycle behind the fill level / overrun it reflects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (count >= CW'(WATERMARK)) | overrun;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a queue-based FIFO model plus a small UartRX emulation.
module tb_uart_rx_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic [15:0]   rx_data = 16'h0000;
    logic          rd      = 1'b0;
    logic          rx_clear;
    logic [15:0]   out;
    logic [AW:0]   count;
`ifdef UART_RX_CTRL_IRQ_EN
    localparam int unsigned WM = 8;
    logic          irq;
    bit            m_irq = 1'b0;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;

    // UartRX emulation state
    bit            uart_dead  = 1'b1;
    bit            clear_pend = 1'b0;
    int            ready      = 0;
    logic [7:0]    tx_q[$];

    // Behavioural model state
    logic [7:0]    mq[$];
    bit            m_ovr    = 1'b0;
    bit            m_clear  = 1'b1;
    bit            m_prev15 = 1'b0;

    uart_rx_ctrl #(
        .DEPTH     (DEPTH),
        .AW        (AW)
`ifdef UART_RX_CTRL_IRQ_EN
        ,
        .WATERMARK (WM)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_clear (rx_clear),
        .rd       (rd),
        .out      (out),
        .count    (count)
`ifdef UART_RX_CTRL_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_out();
        if (mq.size() == 0) return {1'b1, m_ovr, 14'h0};
        return {1'b0, m_ovr, 6'h0, mq[0]};
    endfunction

    // Model: a byte arrives on each 1->0 of rx_data[15] between clock samples;
    // rd pops if non-empty; a push that finds no room sets overrun.
    always @(posedge clk or posedge reset) begin
        bit fall;
        bit rd_eff;
        if (reset) begin
            mq.delete();
            m_ovr    = 1'b0;
            m_clear  = 1'b1;
            m_prev15 = 1'b0;
`ifdef UART_RX_CTRL_IRQ_EN
            m_irq    = 1'b0;
`endif
        end else begin
`ifdef UART_RX_CTRL_IRQ_EN
            m_irq = (mq.size() >= WM) || m_ovr;
`endif
            fall     = m_prev15 && !rx_data[15];
            m_prev15 = rx_data[15];
            rd_eff   = rd && (mq.size() != 0);
            if (rd_eff) begin
                void'(mq.pop_front());
                m_ovr = 1'b0;
            end
            if (fall) begin
                if (mq.size() < DEPTH) mq.push_back(rx_data[7:0]);
                else m_ovr = 1'b1;
            end
            m_clear = fall;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_out", out, exp_out());
        chk("m_count", 16'(count), 16'(mq.size()));
        chk("m_rx_clear", {15'h0, rx_clear}, {15'h0, ~reset & m_clear});
`ifdef UART_RX_CTRL_IRQ_EN
        chk("m_irq", {15'h0, irq}, {15'h0, ~reset & m_irq});
`endif
    end

    // One cycle: emulate UartRX (clear takes effect after the clock it is seen on,
    // a byte is offered only once idle has been sampled), then drive rd.
    task automatic tick(input bit r, input bit r_pres, output bit pres);
        @(negedge clk);
        pres = 1'b0;
        if (!uart_dead) begin
            if (rx_data[15]) ready++;
            if (clear_pend) begin
                rx_data    = 16'h8000;
                ready      = 0;
                clear_pend = 1'b0;
            end
            if (rx_clear) clear_pend = 1'b1;
            if (!reset && !clear_pend && rx_data[15] && ready >= 1 && tx_q.size() != 0) begin
                rx_data = {8'h00, tx_q.pop_front()};
                pres    = 1'b1;
            end
        end
        rd = r | (r_pres & pres);
    endtask

    // Queue one byte and return in the cycle it is presented (optionally with rd).
    task automatic send_byte(input logic [7:0] b, input bit rd_with);
        bit p;
        p = 1'b0;
        tx_q.push_back(b);
        for (int i = 0; i < 20 && !p; i++) tick(1'b0, rd_with, p);
        n_checks++;
        if (!p) begin
            n_fail++;
            tx_q.delete();
            $display("FAIL send_byte timeout: byte %h not accepted within 20 cycles", b);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit p;
        int pulses;
        logic [7:0] e;

        // Reset release with UartRX still showing power-up zeros
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick(1'b0, 1'b0, p);
        chk("rst_clear", {15'h0, rx_clear}, 16'h0001);
        chk("rst_out", out, 16'h8000);
        repeat (5) tick(1'b0, 1'b0, p);
        chk("arm_nopush_cnt", 16'(count), 16'h0000);
        chk("arm_nopush_out", out, 16'h8000);
        uart_dead  = 1'b0;
        rx_data    = 16'h8000;
        ready      = 0;
        clear_pend = 1'b0;

        // Single byte latency and pop
        send_byte(8'h41, 1'b0);
        tick(1'b0, 1'b0, p);
        chk("single_out", out, 16'h0041);
        chk("single_cnt", 16'(count), 16'h0001);
        chk("single_clear", {15'h0, rx_clear}, 16'h0001);
        tick(1'b1, 1'b0, p);
        tick(1'b0, 1'b0, p);
        chk("single_pop_out", out, 16'h8000);
        chk("single_pop_cnt", 16'(count), 16'h0000);

        // Fill to full, then overrun
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        tick(1'b0, 1'b0, p);
        chk("full_cnt", 16'(count), 16'h0010);
        chk("full_out", out, 16'h0000);
        send_byte(8'h55, 1'b0);
        tick(1'b0, 1'b0, p);
        chk("ovr_cnt", 16'(count), 16'h0010);
        chk("ovr_out", out, 16'h4000);
        tick(1'b1, 1'b0, p);
        tick(1'b0, 1'b0, p);
        chk("ovr_rd_out", out, 16'h0001);
        chk("ovr_rd_cnt", 16'(count), 16'h000f);
        repeat (15) tick(1'b1, 1'b0, p);
        tick(1'b0, 1'b0, p);
        chk("drain_cnt", 16'(count), 16'h0000);
        chk("drain_out", out, 16'h8000);

        // Wrap-around: 40 bytes pushed and popped one at a time
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(i), 1'b0);
            tick(1'b0, 1'b0, p);
            chk("wrap_out", out, {8'h00, 8'(i)});
            chk("wrap_cnt", 16'(count), 16'h0001);
            tick(1'b1, 1'b0, p);
        end
        tick(1'b0, 1'b0, p);
        chk("wrap_end_out", out, 16'h8000);

        // Push together with rd while full
        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b0);
        send_byte(8'hA0, 1'b1);
        tick(1'b0, 1'b0, p);
        chk("fullrd_cnt", 16'(count), 16'h0010);
        chk("fullrd_out", out, 16'h0081);
        for (int k = 0; k < 16; k++) begin
            e = (k < 15) ? 8'(8'h81 + k) : 8'hA0;
            chk("fullrd_seq", out, {8'h00, e});
            tick(1'b1, 1'b0, p);
            tick(1'b0, 1'b0, p);
        end
        chk("fullrd_empty", out, 16'h8000);

        // Push together with rd while empty
        send_byte(8'hB7, 1'b1);
        tick(1'b0, 1'b0, p);
        chk("emptyrd_cnt", 16'(count), 16'h0001);
        chk("emptyrd_out", out, 16'h00B7);
        tick(1'b1, 1'b0, p);
        tick(1'b0, 1'b0, p);
        chk("emptyrd_pop", out, 16'h8000);

        // Asynchronous reset with 5 bytes held and the FSM waiting
        for (int i = 0; i < 5; i++) send_byte(8'(8'hD0 + i), 1'b0);
        repeat (4) tick(1'b0, 1'b0, p);
        chk("pre_rst_cnt", 16'(count), 16'h0005);
        #2;
        reset   = 1'b1;
        rx_data = 16'h00EE;
        #1;
        chk("async_rst_out", out, 16'h8000);
        chk("async_rst_cnt", 16'(count), 16'h0000);
        repeat (2) tick(1'b0, 1'b0, p);
        @(posedge clk);
        #1 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0, p);
            if (rx_clear) pulses++;
        end
        chk("post_rst_pulses", 16'(pulses), 16'h0001);
        chk("post_rst_cnt", 16'(count), 16'h0000);

`ifdef UART_RX_CTRL_IRQ_EN
        // Watermark interrupt
        for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), 1'b0);
        tick(1'b0, 1'b0, p);
        chk("irq_cnt8", 16'(count), 16'h0008);
        chk("irq_lag", {15'h0, irq}, 16'h0000);
        tick(1'b0, 1'b0, p);
        chk("irq_set", {15'h0, irq}, 16'h0001);
        tick(1'b1, 1'b0, p);
        tick(1'b0, 1'b0, p);
        chk("irq_hold", {15'h0, irq}, 16'h0001);
        tick(1'b0, 1'b0, p);
        chk("irq_clr", {15'h0, irq}, 16'h0000);
`endif

        tick(1'b0, 1'b0, p);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
